// File: rtl/seq_alu.sv
// seq_alu: single-cycle logic/arith/shift ops plus a WIDTH-cycle shift-add multiplier
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_z,
  output logic             o_zero,
  output logic             o_ovf,
  output logic             o_busy,
  output logic             o_done
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_z, r_acc, r_mcand, r_mplier, w_res, w_sum, w_bx, w_acc_n;
  logic [CW-1:0] r_cnt;
  logic r_zero, r_ovf, w_sub, w_ovf, w_accept, w_last, w_is_mul;
  assign w_sub = i_op == 3'b110;
  assign w_bx = w_sub ? ~i_b : i_b;
  assign w_sum = i_a + w_bx + WIDTH'(w_sub);
  assign w_ovf = (i_op == 3'b010 || w_sub) && (i_a[WIDTH-1] == w_bx[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);
  assign w_is_mul = i_op == 3'b101;
  assign w_accept = i_start && r_state != MUL;
  assign w_last = r_cnt == CW'(1);
  assign w_acc_n = r_acc + (r_mplier[0] ? r_mcand : '0);
  always_comb begin
    w_res = '0;
    case (i_op)
      3'b000: w_res = i_a & i_b;
      3'b001: w_res = i_a | i_b;
      3'b010, 3'b110: w_res = w_sum;
      3'b111: w_res = WIDTH'($signed(i_a) < $signed(i_b));
      3'b011: w_res = i_a << i_b[SW-1:0];
      3'b100: w_res = i_a >> i_b[SW-1:0];
      default: w_res = '0;
    endcase
  end
  always_comb begin
    w_next = r_state == MUL ? (w_last ? DONE : MUL) : w_accept ? (w_is_mul ? MUL : DONE) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_z <= '0;
      r_zero <= 1'b1;
      r_ovf <= 1'b0;
      r_acc <= '0;
      r_mcand <= '0;
      r_mplier <= '0;
      r_cnt <= '0;
    end else if (r_state == MUL) begin
      r_acc <= w_acc_n;
      r_mcand <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt <= r_cnt - CW'(1);
      if (w_last) begin
        r_z <= w_acc_n;
        r_zero <= w_acc_n == '0;
        r_ovf <= 1'b0;
      end
    end else if (w_accept && w_is_mul) begin
      r_acc <= '0;
      r_mcand <= i_a;
      r_mplier <= i_b;
      r_cnt <= CW'(WIDTH);
    end else if (w_accept) begin
      r_z <= w_res;
      r_zero <= w_res == '0;
      r_ovf <= w_ovf;
    end
  end
  assign o_z = r_z;
  assign o_zero = r_zero;
  assign o_ovf = r_ovf;
  assign o_busy = r_state == MUL;
  assign o_done = r_state == DONE;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: random and directed checks of seq_alu against a behavioural model
module tb_seq_alu;
  logic clk = 1'b0;
  logic rst, start;
  logic [2:0] op;
  logic [31:0] a, b, z;
  logic zero, ovf, busy, done;
  logic s8;
  logic [2:0] op8;
  logic [7:0] a8, b8, z8;
  logic zero8, ovf8, busy8, done8;
  int total = 0;
  int bad = 0;
  bit chk_en = 0;
  logic [31:0] exp_z = '0;
  logic exp_zero = 1'b1;
  logic exp_ovf = 1'b0;
  logic exp_done = 1'b0;
  int mul_left = 0;
  logic [31:0] mul_res;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_op(op), .i_a(a), .i_b(b),
    .o_z(z), .o_zero(zero), .o_ovf(ovf), .o_busy(busy), .o_done(done)
  );
  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .i_start(s8), .i_op(op8), .i_a(a8), .i_b(b8),
    .o_z(z8), .o_zero(zero8), .o_ovf(ovf8), .o_busy(busy8), .o_done(done8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output logic v);
    longint sx, sy, s;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    v = 1'b0;
    r = '0;
    case (o)
      3'b000: r = x & y;
      3'b001: r = x | y;
      3'b010: begin s = sx + sy; r = x + y; v = s > 64'sd2147483647 || s < -64'sd2147483648; end
      3'b110: begin s = sx - sy; r = x - y; v = s > 64'sd2147483647 || s < -64'sd2147483648; end
      3'b111: r = (sx < sy) ? 32'd1 : 32'd0;
      3'b011: r = x << (y % 32);
      3'b100: r = x >> (y % 32);
      default: r = '0;
    endcase
  endtask

  task automatic step(input logic r_i, input logic s_i, input logic [2:0] o_i,
                      input logic [31:0] a_i, input logic [31:0] b_i);
    logic [31:0] res;
    logic v;
    rst = r_i; start = s_i; op = o_i; a = a_i; b = b_i;
    @(posedge clk);
    if (r_i) begin
      exp_z = '0; exp_zero = 1'b1; exp_ovf = 1'b0; exp_done = 1'b0; mul_left = 0;
    end else if (mul_left > 0) begin
      mul_left--;
      exp_done = mul_left == 0;
      if (mul_left == 0) begin
        exp_z = mul_res; exp_zero = mul_res == 0; exp_ovf = 1'b0;
      end
    end else if (s_i && o_i == 3'b101) begin
      mul_res = 32'(longint'(a_i) * longint'(b_i));
      mul_left = 32;
      exp_done = 1'b0;
    end else if (s_i) begin
      ref_op(o_i, a_i, b_i, res, v);
      exp_z = res; exp_zero = res == 0; exp_ovf = v; exp_done = 1'b1;
    end else exp_done = 1'b0;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_z", z, exp_z);
      check("model_zero", zero, exp_zero);
      check("model_ovf", ovf, exp_ovf);
      check("model_busy", busy, mul_left > 0);
      check("model_done", done, exp_done);
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    int cnt;
    s8 = 0; op8 = '0; a8 = '0; b8 = '0;
    @(negedge clk);
    step(1, 1, 3'b010, 32'd1, 32'd2);
    step(1, 1, 3'b101, 32'd3, 32'd4);
    chk_en = 1;
    check("rst_z", z, 32'h0);
    check("rst_zero", zero, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    step(0, 1, 3'b010, 32'h7FFFFFFF, 32'h1);
    check("add_ovf_z", z, 32'h80000000);
    check("add_ovf_ovf", ovf, 1'b1);
    check("add_ovf_zero", zero, 1'b0);
    check("add_ovf_done", done, 1'b1);
    step(0, 1, 3'b110, 32'd5, 32'd5);
    check("sub_z", z, 32'h0);
    check("sub_zero", zero, 1'b1);
    check("sub_done", done, 1'b1);
    step(0, 1, 3'b000, 32'hF0F0F0F0, 32'h0FF00FF0);
    check("and_b2b_z", z, 32'h00F000F0);
    check("and_b2b_done", done, 1'b1);
    step(0, 1, 3'b111, 32'hFFFFFFFF, 32'h1);
    check("slt_neg_z", z, 32'h1);
    check("slt_neg_ovf", ovf, 1'b0);
    step(0, 1, 3'b111, 32'h1, 32'hFFFFFFFF);
    check("slt_pos_z", z, 32'h0);
    step(0, 1, 3'b111, 32'h80000000, 32'h1);
    check("slt_min_z", z, 32'h1);
    step(0, 0, 3'b000, 32'h0, 32'h0);
    check("idle_done", done, 1'b0);
    check("idle_hold_z", z, 32'h1);
    step(0, 1, 3'b101, 32'd1234, 32'd5678);
    cnt = 0;
    n = 0;
    while (!done && n < 40) begin
      if (busy) cnt++;
      step(0, n == 5, n == 5 ? 3'b010 : 3'b101, $urandom, $urandom);
      n++;
    end
    check("mul_busy_cycles", cnt, 32);
    check("mul_z", z, 32'd7006652);
    check("mul_done", done, 1'b1);
    step(0, 0, 3'b000, 32'h0, 32'h0);
    check("mul_done_pulse", done, 1'b0);
    check("mul_hold_z", z, 32'd7006652);
    step(0, 1, 3'b101, 32'hDEADBEEF, 32'h12345);
    for (int i = 0; i < 9; i++) step(0, 0, 3'b000, 32'h0, 32'h0);
    check("abort_busy_before", busy, 1'b1);
    step(1, 0, 3'b000, 32'h0, 32'h0);
    check("abort_z", z, 32'h0);
    check("abort_zero", zero, 1'b1);
    check("abort_busy", busy, 1'b0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 0, 3'b000, 32'h0, 32'h0);
      if (done) cnt++;
    end
    check("abort_no_done", cnt, 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), pick(), pick());
    while (mul_left > 0) step(0, 0, 3'b000, 32'h0, 32'h0);
    step(0, 0, 3'b000, 32'h0, 32'h0);
    s8 = 1; op8 = 3'b011; a8 = 8'h81; b8 = 8'h09;
    step(0, 0, 3'b000, 32'h0, 32'h0);
    check("w8_sll_z", z8, 8'h02);
    check("w8_sll_done", done8, 1'b1);
    op8 = 3'b100; a8 = 8'h80; b8 = 8'd7;
    step(0, 0, 3'b000, 32'h0, 32'h0);
    check("w8_srl_z", z8, 8'h01);
    op8 = 3'b101; a8 = 8'h10; b8 = 8'h10;
    step(0, 0, 3'b000, 32'h0, 32'h0);
    s8 = 0;
    cnt = 0;
    n = 0;
    while (!done8 && n < 20) begin
      if (busy8) cnt++;
      step(0, 0, 3'b000, 32'h0, 32'h0);
      n++;
    end
    check("w8_mul_busy_cycles", cnt, 8);
    check("w8_mul_z", z8, 8'h00);
    check("w8_mul_zero", zero8, 1'b1);
    check("w8_mul_done", done8, 1'b1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
